// File: rtl/mem_stage.sv
// mem_stage: memory/writeback pipeline stage. Retires ALU results, branches and
// jumps in one negedge, and runs LDW/STW through a data-memory handshake that
// has a timeout abort. All state updates on the falling edge of I_CLOCK.
//
// Opcode map (OPCODE_WIDTH must be >= 5; values are zero-extended):
//   0_0nzp  BR with condition bits n/z/p in [2:0] (nzp=000 is a never-taken NOP)
//   0x08 ADD   0x09 ADDI  0x0A AND   0x0B ANDI  0x0C MOV   0x0D MOVI
//   0x0E LDW   0x0F STW   0x10 JMP   0x11 JSR   0x12 JSRR
//   anything else retires as a bubble.
module mem_stage #(
  parameter int MEM_TIMEOUT  = 64,
  parameter int OPCODE_WIDTH = 5,
  parameter int REG_WIDTH    = 16,
  parameter int PC_WIDTH     = 16
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET,
  input  logic                    I_LOCK,
  input  logic                    I_FetchStall,
  input  logic                    I_DepStall,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [REG_WIDTH-1:0]    I_ALUOut,
  input  logic [3:0]              I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]    I_DestValue,
  output logic                    O_MemReq,
  output logic                    O_MemWe,
  output logic [REG_WIDTH-1:0]    O_MemAddr,
  output logic [REG_WIDTH-1:0]    O_MemWData,
  input  logic                    I_MemAck,
  input  logic [REG_WIDTH-1:0]    I_MemRData,
  output logic                    O_LOCK,
  output logic                    O_FetchStall,
  output logic                    O_DepStall,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [3:0]              O_DestRegIdx,
  output logic [REG_WIDTH-1:0]    O_DestValue,
  output logic                    O_RegWrite,
  output logic                    O_BranchTaken,
  output logic [PC_WIDTH-1:0]     O_BranchPC,
  output logic                    O_MemBusy,
  output logic                    O_MemErr
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(8'h08);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(8'h09);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(8'h0A);
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI = OPCODE_WIDTH'(8'h0B);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV  = OPCODE_WIDTH'(8'h0C);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOVI = OPCODE_WIDTH'(8'h0D);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW  = OPCODE_WIDTH'(8'h0E);
  localparam logic [OPCODE_WIDTH-1:0] OP_STW  = OPCODE_WIDTH'(8'h0F);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(8'h10);
  localparam logic [OPCODE_WIDTH-1:0] OP_JSR  = OPCODE_WIDTH'(8'h11);
  localparam logic [OPCODE_WIDTH-1:0] OP_JSRR = OPCODE_WIDTH'(8'h12);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LD_WAIT = 2'd1,
    ST_ST_WAIT = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CNT_W-1:0]        r_wait_cnt;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    w_accept;
  logic                    w_done_ack;
  logic                    w_done_timeout;
  logic                    w_is_br;
  logic                    w_br_taken;
  logic [2:0]              r_nzp;
  logic [OPCODE_WIDTH-1:0] r_pend_op;
  logic [3:0]              r_pend_dst;

  // Condition codes for a retiring result: exactly one of N/Z/P set.
  function automatic logic [2:0] f_nzp(input logic [REG_WIDTH-1:0] v);
    if (v[REG_WIDTH-1])  return 3'b100;
    else if (v == '0)    return 3'b010;
    else                 return 3'b001;
  endfunction

  assign O_MemBusy  = (r_state != ST_IDLE);
  assign w_is_br    = (I_Opcode[OPCODE_WIDTH-1:3] == '0);
  assign w_br_taken = |(I_Opcode[2:0] & r_nzp);

  // Next-state logic: acceptance in IDLE, ack/timeout completion in WAIT.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_state_next   = r_state;
    w_accept       = 1'b0;
    w_done_ack     = 1'b0;
    w_done_timeout = 1'b0;
    w_cnt_inc      = r_wait_cnt + 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_accept = I_LOCK & ~I_FetchStall & ~I_DepStall;
        if (w_accept && (I_Opcode == OP_LDW))      w_state_next = ST_LD_WAIT;
        else if (w_accept && (I_Opcode == OP_STW)) w_state_next = ST_ST_WAIT;
      end
      ST_LD_WAIT, ST_ST_WAIT: begin
        if (I_MemAck) begin
          w_done_ack   = 1'b1;
          w_state_next = ST_IDLE;
        end else if (w_cnt_inc == TIMEOUT_C) begin
          w_done_timeout = 1'b1;
          w_state_next   = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register and wait counter; counter is zero on entry to WAIT.
  always_ff @(negedge I_CLOCK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (I_RESET) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE) r_wait_cnt <= '0;
      else                    r_wait_cnt <= w_cnt_inc;
    end
  end

  // Datapath: pass-through flags, writeback bundle, memory port, NZP, error flag.
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      O_LOCK        <= 1'b0;
      O_FetchStall  <= 1'b0;
      O_DepStall    <= 1'b0;
      O_Opcode      <= '0;
      O_DestRegIdx  <= '0;
      O_DestValue   <= '0;
      O_RegWrite    <= 1'b0;
      O_BranchTaken <= 1'b0;
      O_BranchPC    <= '0;
      O_MemReq      <= 1'b0;
      O_MemWe       <= 1'b0;
      O_MemAddr     <= '0;
      O_MemWData    <= '0;
      O_MemErr      <= 1'b0;
      r_nzp         <= 3'b010;
      r_pend_op     <= '0;
      r_pend_dst    <= '0;
    end else begin
      O_LOCK        <= I_LOCK;
      O_FetchStall  <= I_FetchStall;
      O_DepStall    <= I_DepStall;
      // Bubble unless something below retires.
      O_RegWrite    <= 1'b0;
      O_BranchTaken <= 1'b0;

      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          case (I_Opcode)
            OP_ADD, OP_ADDI, OP_AND, OP_ANDI, OP_MOV, OP_MOVI: begin
              O_Opcode     <= I_Opcode;
              O_DestRegIdx <= I_DestRegIdx;
              O_DestValue  <= I_ALUOut;
              O_RegWrite   <= 1'b1;
              r_nzp        <= f_nzp(I_ALUOut);
            end
            OP_LDW, OP_STW: begin
              O_MemReq   <= 1'b1;
              O_MemWe    <= (I_Opcode == OP_STW);
              O_MemAddr  <= I_ALUOut;
              O_MemWData <= (I_Opcode == OP_STW) ? I_DestValue : '0;
              r_pend_op  <= I_Opcode;
              r_pend_dst <= I_DestRegIdx;
            end
            OP_JMP: begin
              O_Opcode      <= I_Opcode;
              O_BranchTaken <= 1'b1;
              O_BranchPC    <= I_DestValue[PC_WIDTH-1:0];
            end
            OP_JSR, OP_JSRR: begin
              O_Opcode      <= I_Opcode;
              O_BranchTaken <= 1'b1;
              O_BranchPC    <= I_DestValue[PC_WIDTH-1:0];
              O_DestRegIdx  <= I_DestRegIdx;
              O_DestValue   <= I_ALUOut;
              O_RegWrite    <= 1'b1;
            end
            default: begin
              if (w_is_br) begin
                O_Opcode <= I_Opcode;
                if (w_br_taken) begin
                  O_BranchTaken <= 1'b1;
                  O_BranchPC    <= I_DestValue[PC_WIDTH-1:0];
                end
              end
            end
          endcase
        end
      end else if (w_done_ack || w_done_timeout) begin
        O_MemReq     <= 1'b0;
        O_MemWe      <= 1'b0;
        O_MemAddr    <= '0;
        O_MemWData   <= '0;
        O_Opcode     <= r_pend_op;
        O_DestRegIdx <= r_pend_dst;
        if (w_done_ack && (r_state == ST_LD_WAIT)) begin
          O_DestValue <= I_MemRData;
          O_RegWrite  <= 1'b1;
          r_nzp       <= f_nzp(I_MemRData);
        end
        if (w_done_timeout) O_MemErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with MEM_TIMEOUT=4.
// Inputs change just after the rising edge; the DUT samples them on the next
// falling edge; outputs are observed just after the following rising edge.
module tb_mem_stage;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_BRN  = 5'h04;
  localparam logic [4:0] OP_BRZ  = 5'h02;
  localparam logic [4:0] OP_BRP  = 5'h01;
  localparam logic [4:0] OP_ADD  = 5'h08;
  localparam logic [4:0] OP_ADDI = 5'h09;
  localparam logic [4:0] OP_AND  = 5'h0A;
  localparam logic [4:0] OP_MOVI = 5'h0D;
  localparam logic [4:0] OP_LDW  = 5'h0E;
  localparam logic [4:0] OP_STW  = 5'h0F;
  localparam logic [4:0] OP_JMP  = 5'h10;
  localparam logic [4:0] OP_JSR  = 5'h11;
  localparam logic [4:0] OP_BAD  = 5'h1F;

  logic        I_CLOCK = 1'b0;
  logic        I_RESET, I_LOCK, I_FetchStall, I_DepStall;
  logic [4:0]  I_Opcode;
  logic [15:0] I_ALUOut, I_DestValue, I_MemRData;
  logic [3:0]  I_DestRegIdx;
  logic        I_MemAck;
  logic        O_MemReq, O_MemWe, O_LOCK, O_FetchStall, O_DepStall;
  logic [15:0] O_MemAddr, O_MemWData, O_DestValue;
  logic [4:0]  O_Opcode;
  logic [3:0]  O_DestRegIdx;
  logic        O_RegWrite, O_BranchTaken, O_MemBusy, O_MemErr;
  logic [15:0] O_BranchPC;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 I_CLOCK = ~I_CLOCK;

  mem_stage #(.MEM_TIMEOUT(4), .OPCODE_WIDTH(5), .REG_WIDTH(16), .PC_WIDTH(16)) dut (
    .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK),
    .I_FetchStall(I_FetchStall), .I_DepStall(I_DepStall),
    .I_Opcode(I_Opcode), .I_ALUOut(I_ALUOut), .I_DestRegIdx(I_DestRegIdx),
    .I_DestValue(I_DestValue),
    .O_MemReq(O_MemReq), .O_MemWe(O_MemWe), .O_MemAddr(O_MemAddr),
    .O_MemWData(O_MemWData), .I_MemAck(I_MemAck), .I_MemRData(I_MemRData),
    .O_LOCK(O_LOCK), .O_FetchStall(O_FetchStall), .O_DepStall(O_DepStall),
    .O_Opcode(O_Opcode), .O_DestRegIdx(O_DestRegIdx), .O_DestValue(O_DestValue),
    .O_RegWrite(O_RegWrite), .O_BranchTaken(O_BranchTaken), .O_BranchPC(O_BranchPC),
    .O_MemBusy(O_MemBusy), .O_MemErr(O_MemErr)
  );

  // One falling (active) edge passes, then land just after the next rising edge.
  task automatic step();
    @(negedge I_CLOCK);
    @(posedge I_CLOCK);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [15:0] alu,
                       input logic [3:0] dst, input logic [15:0] dval);
    I_Opcode     = op;
    I_ALUOut     = alu;
    I_DestRegIdx = dst;
    I_DestValue  = dval;
  endtask

  task automatic test_reset();
    I_RESET = 1'b1; I_LOCK = 1'b1; I_FetchStall = 1'b0; I_DepStall = 1'b0;
    I_MemAck = 1'b0; I_MemRData = '0;
    drive(OP_NOP, 16'h0, 4'h0, 16'h0);
    step();
    n_checks++; if (O_MemReq !== 1'b0) begin n_fail++; $display("FAIL rst_memreq: got %b want 0", O_MemReq); end
    n_checks++; if (O_MemErr !== 1'b0) begin n_fail++; $display("FAIL rst_memerr: got %b want 0", O_MemErr); end
    n_checks++; if (O_LOCK !== 1'b0) begin n_fail++; $display("FAIL rst_lock: got %b want 0", O_LOCK); end
    n_checks++; if (O_RegWrite !== 1'b0) begin n_fail++; $display("FAIL rst_regwrite: got %b want 0", O_RegWrite); end
    n_checks++; if (O_BranchTaken !== 1'b0) begin n_fail++; $display("FAIL rst_brtaken: got %b want 0", O_BranchTaken); end
    n_checks++; if (O_MemBusy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", O_MemBusy); end
    n_checks++; if (O_DestValue !== 16'h0) begin n_fail++; $display("FAIL rst_destval: got %h want 0000", O_DestValue); end
    n_checks++; if (dut.r_nzp !== 3'b010) begin n_fail++; $display("FAIL rst_nzp: got %b want 010", dut.r_nzp); end
    I_RESET = 1'b0;
    step();
    n_checks++; if (O_LOCK !== 1'b1) begin n_fail++; $display("FAIL lock_pass: got %b want 1", O_LOCK); end
  endtask

  task automatic test_alu();
    drive(OP_ADDI, 16'hFFFE, 4'h3, 16'h0);
    step();
    n_checks++; if (O_DestValue !== 16'hFFFE) begin n_fail++; $display("FAIL addi_val: got %h want fffe", O_DestValue); end
    n_checks++; if (O_RegWrite !== 1'b1) begin n_fail++; $display("FAIL addi_we: got %b want 1", O_RegWrite); end
    n_checks++; if (O_DestRegIdx !== 4'h3) begin n_fail++; $display("FAIL addi_dst: got %h want 3", O_DestRegIdx); end
    n_checks++; if (dut.r_nzp !== 3'b100) begin n_fail++; $display("FAIL addi_nzp: got %b want 100", dut.r_nzp); end
    drive(OP_ADD, 16'h0000, 4'h4, 16'h0);
    step();
    n_checks++; if (dut.r_nzp !== 3'b010) begin n_fail++; $display("FAIL add0_nzp: got %b want 010", dut.r_nzp); end
    drive(OP_MOVI, 16'h0005, 4'h5, 16'h0);
    step();
    n_checks++; if (dut.r_nzp !== 3'b001) begin n_fail++; $display("FAIL movi_nzp: got %b want 001", dut.r_nzp); end
    n_checks++; if (O_DestValue !== 16'h0005) begin n_fail++; $display("FAIL movi_val: got %h want 0005", O_DestValue); end
    drive(OP_BAD, 16'h7777, 4'h6, 16'h0);
    step();
    n_checks++; if (O_RegWrite !== 1'b0) begin n_fail++; $display("FAIL bad_we: got %b want 0", O_RegWrite); end
    n_checks++; if (O_DestValue !== 16'h0005) begin n_fail++; $display("FAIL bad_val: got %h want 0005", O_DestValue); end
  endtask

  task automatic test_branch();
    drive(OP_AND, 16'h0000, 4'h1, 16'h0);
    step();
    drive(OP_BRZ, 16'h0000, 4'h0, 16'h0100);
    step();
    n_checks++; if (O_BranchTaken !== 1'b1) begin n_fail++; $display("FAIL brz_taken: got %b want 1", O_BranchTaken); end
    n_checks++; if (O_BranchPC !== 16'h0100) begin n_fail++; $display("FAIL brz_pc: got %h want 0100", O_BranchPC); end
    n_checks++; if (O_RegWrite !== 1'b0) begin n_fail++; $display("FAIL brz_we: got %b want 0", O_RegWrite); end
    drive(OP_NOP, 16'h0, 4'h0, 16'h0);
    step();
    n_checks++; if (O_BranchTaken !== 1'b0) begin n_fail++; $display("FAIL br_pulse: got %b want 0", O_BranchTaken); end
    drive(OP_BRP, 16'h0000, 4'h0, 16'h0200);
    step();
    n_checks++; if (O_BranchTaken !== 1'b0) begin n_fail++; $display("FAIL brp_taken: got %b want 0", O_BranchTaken); end
    drive(OP_BRN, 16'h0000, 4'h0, 16'h0280);
    step();
    n_checks++; if (O_BranchTaken !== 1'b0) begin n_fail++; $display("FAIL brn_taken: got %b want 0", O_BranchTaken); end
    drive(OP_JMP, 16'h0000, 4'h0, 16'h0300);
    step();
    n_checks++; if (O_BranchTaken !== 1'b1 || O_BranchPC !== 16'h0300) begin n_fail++; $display("FAIL jmp: got %b/%h want 1/0300", O_BranchTaken, O_BranchPC); end
    drive(OP_JSR, 16'h0042, 4'h7, 16'h0400);
    step();
    n_checks++; if (O_BranchTaken !== 1'b1 || O_BranchPC !== 16'h0400) begin n_fail++; $display("FAIL jsr_br: got %b/%h want 1/0400", O_BranchTaken, O_BranchPC); end
    n_checks++; if (O_RegWrite !== 1'b1 || O_DestValue !== 16'h0042 || O_DestRegIdx !== 4'h7) begin n_fail++; $display("FAIL jsr_link: got %b/%h/%h want 1/0042/7", O_RegWrite, O_DestValue, O_DestRegIdx); end
    n_checks++; if (dut.r_nzp !== 3'b010) begin n_fail++; $display("FAIL jsr_nzp: got %b want 010", dut.r_nzp); end
  endtask

  task automatic test_load();
    I_MemAck = 1'b0;
    drive(OP_LDW, 16'h0040, 4'h2, 16'h0);
    step();
    n_checks++; if (O_MemReq !== 1'b1 || O_MemWe !== 1'b0) begin n_fail++; $display("FAIL ld_req: got %b/%b want 1/0", O_MemReq, O_MemWe); end
    n_checks++; if (O_MemBusy !== 1'b1) begin n_fail++; $display("FAIL ld_busy0: got %b want 1", O_MemBusy); end
    n_checks++; if (O_RegWrite !== 1'b0) begin n_fail++; $display("FAIL ld_bubble: got %b want 0", O_RegWrite); end
    drive(OP_ADD, 16'h5555, 4'h9, 16'h0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (O_MemAddr !== 16'h0040) begin n_fail++; $display("FAIL ld_addr_hold%0d: got %h want 0040", i, O_MemAddr); end
      n_checks++; if (O_MemBusy !== 1'b1 || O_MemReq !== 1'b1) begin n_fail++; $display("FAIL ld_wait%0d: got busy %b req %b want 1/1", i, O_MemBusy, O_MemReq); end
      if (i == 2) begin I_MemAck = 1'b1; I_MemRData = 16'h1234; end
      step();
    end
    I_MemAck = 1'b0;
    n_checks++; if (O_MemReq !== 1'b0 || O_MemBusy !== 1'b0) begin n_fail++; $display("FAIL ld_done: got req %b busy %b want 0/0", O_MemReq, O_MemBusy); end
    n_checks++; if (O_DestValue !== 16'h1234 || O_RegWrite !== 1'b1 || O_DestRegIdx !== 4'h2) begin n_fail++; $display("FAIL ld_wb: got %h/%b/%h want 1234/1/2", O_DestValue, O_RegWrite, O_DestRegIdx); end
    n_checks++; if (dut.r_nzp !== 3'b001) begin n_fail++; $display("FAIL ld_nzp: got %b want 001", dut.r_nzp); end
    drive(OP_NOP, 16'h0, 4'h0, 16'h0);
    step();
  endtask

  task automatic test_min_latency();
    I_MemAck = 1'b1; I_MemRData = 16'h8000;
    drive(OP_LDW, 16'h0050, 4'hA, 16'h0);
    step();
    n_checks++; if (O_MemReq !== 1'b1 || O_RegWrite !== 1'b0) begin n_fail++; $display("FAIL idle_ack: got req %b we %b want 1/0", O_MemReq, O_RegWrite); end
    I_LOCK = 1'b0;
    drive(OP_ADD, 16'h0007, 4'hB, 16'h0);
    step();
    I_MemAck = 1'b0;
    n_checks++; if (O_RegWrite !== 1'b1 || O_DestValue !== 16'h8000 || O_MemReq !== 1'b0) begin n_fail++; $display("FAIL lat2_done: got %b/%h/%b want 1/8000/0", O_RegWrite, O_DestValue, O_MemReq); end
    n_checks++; if (dut.r_nzp !== 3'b100) begin n_fail++; $display("FAIL lat2_nzp: got %b want 100", dut.r_nzp); end
    step();
    n_checks++; if (O_RegWrite !== 1'b0 || O_LOCK !== 1'b0) begin n_fail++; $display("FAIL unlock_hold: got we %b lock %b want 0/0", O_RegWrite, O_LOCK); end
    I_LOCK = 1'b1;
    step();
    n_checks++; if (O_RegWrite !== 1'b1 || O_DestValue !== 16'h0007) begin n_fail++; $display("FAIL relock_add: got %b/%h want 1/0007", O_RegWrite, O_DestValue); end
  endtask

  task automatic test_store_timeout();
    I_MemAck = 1'b0;
    drive(OP_STW, 16'h0010, 4'h0, 16'h00AB);
    step();
    n_checks++; if (O_MemReq !== 1'b1 || O_MemWe !== 1'b1 || O_MemAddr !== 16'h0010 || O_MemWData !== 16'h00AB) begin n_fail++; $display("FAIL st_req: got %b/%b/%h/%h want 1/1/0010/00ab", O_MemReq, O_MemWe, O_MemAddr, O_MemWData); end
    drive(OP_NOP, 16'h0, 4'h0, 16'h0);
    for (int i = 1; i < 4; i++) begin
      step();
      n_checks++; if (O_MemReq !== 1'b1 || O_MemErr !== 1'b0) begin n_fail++; $display("FAIL st_wait%0d: got req %b err %b want 1/0", i, O_MemReq, O_MemErr); end
    end
    step();
    n_checks++; if (O_MemReq !== 1'b0 || O_MemBusy !== 1'b0) begin n_fail++; $display("FAIL st_timeout: got req %b busy %b want 0/0", O_MemReq, O_MemBusy); end
    n_checks++; if (O_MemErr !== 1'b1 || O_RegWrite !== 1'b0) begin n_fail++; $display("FAIL st_err: got err %b we %b want 1/0", O_MemErr, O_RegWrite); end
    n_checks++; if (dut.r_nzp !== 3'b001) begin n_fail++; $display("FAIL st_nzp: got %b want 001", dut.r_nzp); end
    drive(OP_ADD, 16'h0003, 4'h1, 16'h0);
    step();
    step();
    n_checks++; if (O_MemErr !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", O_MemErr); end
    I_RESET = 1'b1;
    step();
    I_RESET = 1'b0;
    n_checks++; if (O_MemErr !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", O_MemErr); end
  endtask

  task automatic test_reset_mid_wait();
    drive(OP_MOVI, 16'hFFFF, 4'h2, 16'h0);
    step();
    I_MemAck = 1'b0;
    drive(OP_LDW, 16'h0080, 4'h3, 16'h0);
    step();
    drive(OP_NOP, 16'h0, 4'h0, 16'h0);
    step();
    I_RESET = 1'b1; I_MemAck = 1'b1; I_MemRData = 16'hBEEF;
    step();
    n_checks++; if (O_MemReq !== 1'b0 || O_MemBusy !== 1'b0) begin n_fail++; $display("FAIL rstw_req: got req %b busy %b want 0/0", O_MemReq, O_MemBusy); end
    n_checks++; if (O_RegWrite !== 1'b0 || O_DestValue !== 16'h0) begin n_fail++; $display("FAIL rstw_wb: got %b/%h want 0/0000", O_RegWrite, O_DestValue); end
    n_checks++; if (dut.r_nzp !== 3'b010) begin n_fail++; $display("FAIL rstw_nzp: got %b want 010", dut.r_nzp); end
    I_RESET = 1'b0;
    step();
    I_MemAck = 1'b0;
    n_checks++; if (O_RegWrite !== 1'b0 || O_MemReq !== 1'b0) begin n_fail++; $display("FAIL rstw_after: got we %b req %b want 0/0", O_RegWrite, O_MemReq); end
  endtask

  task automatic test_stalls();
    I_DepStall = 1'b1;
    drive(OP_ADD, 16'h0011, 4'h4, 16'h0);
    step();
    n_checks++; if (O_RegWrite !== 1'b0 || O_DepStall !== 1'b1) begin n_fail++; $display("FAIL depstall: got we %b dep %b want 0/1", O_RegWrite, O_DepStall); end
    I_DepStall = 1'b0; I_FetchStall = 1'b1;
    drive(OP_STW, 16'h0020, 4'h0, 16'h0001);
    step();
    n_checks++; if (O_MemReq !== 1'b0 || O_FetchStall !== 1'b1) begin n_fail++; $display("FAIL fetchstall: got req %b fs %b want 0/1", O_MemReq, O_FetchStall); end
    I_FetchStall = 1'b0;
    drive(OP_ADD, 16'h0011, 4'h4, 16'h0);
    step();
    n_checks++; if (O_RegWrite !== 1'b1 || O_DepStall !== 1'b0 || O_FetchStall !== 1'b0) begin n_fail++; $display("FAIL unstall: got we %b dep %b fs %b want 1/0/0", O_RegWrite, O_DepStall, O_FetchStall); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_load();
    test_min_latency();
    test_store_timeout();
    test_reset_mid_wait();
    test_stalls();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 64, meaning the maximum wait cycles for I_MemAck before a transaction aborts.
REQ-002 SHALL have ports I_CLOCK in 1, stage clock; all state updates on its negedge.
REQ-003 SHALL have I_RESET in 1; one clock, reset synchronous and active-high.
REQ-004 SHALL have I_LOCK in 1, upstream lock; I_FetchStall in 1, I_DepStall in 1, upstream bubble flags.
REQ-005 SHALL have I_Opcode in OPCODE_WIDTH; I_ALUOut in REG_WIDTH, result or address; I_DestRegIdx in 4; I_DestValue in REG_WIDTH, store data or branch target.
REQ-006 SHALL have O_MemReq out 1, O_MemWe out 1, O_MemAddr out REG_WIDTH, O_MemWData out REG_WIDTH, I_MemAck in 1, I_MemRData in REG_WIDTH, data-memory port.
REQ-007 SHALL have O_LOCK out 1, O_FetchStall out 1, O_DepStall out 1, registered pass-through of the inputs.
REQ-008 SHALL have O_Opcode out OPCODE_WIDTH, O_DestRegIdx out 4, O_DestValue out REG_WIDTH, O_RegWrite out 1, writeback bundle.
REQ-009 SHALL have O_BranchTaken out 1, O_BranchPC out PC_WIDTH, redirect to fetch; O_MemBusy out 1, upstream hold; O_MemErr out 1, sticky timeout flag.

Function
REQ-010 SHALL accept an instruction on a negedge when I_LOCK=1, I_FetchStall=0, I_DepStall=0, and FSM=IDLE; otherwise, in IDLE, it SHALL retire a bubble: O_RegWrite=0, O_BranchTaken=0.
REQ-011 SHALL implement FSM states IDLE, LD_WAIT, ST_WAIT; IDLE->LD_WAIT on accepted LDW, IDLE->ST_WAIT on accepted STW, WAIT->IDLE on I_MemAck=1 or timeout.
REQ-012 ADD/ADDI/AND/ANDI/MOV/MOVI SHALL retire one edge after acceptance: O_DestValue=I_ALUOut, O_DestRegIdx passed, O_RegWrite=1, NZP updated.
REQ-013 NZP SHALL be a 3-bit register: N = result[REG_WIDTH-1], Z = (result==0), P = otherwise; exactly one bit set.
REQ-014 On LDW acceptance the block SHALL drive O_MemReq=1, O_MemWe=0, O_MemAddr=I_ALUOut, and latch opcode and destination.
REQ-015 On STW acceptance the block SHALL drive O_MemReq=1, O_MemWe=1, O_MemAddr=I_ALUOut, O_MemWData=I_DestValue.
REQ-016 O_MemReq, O_MemWe, O_MemAddr, and O_MemWData SHALL hold stable throughout WAIT and drop on the edge that samples I_MemAck=1.
REQ-017 I_MemAck SHALL be sampled only in WAIT states; minimum memory op latency SHALL be 2 edges; an ack in IDLE SHALL be ignored.
REQ-018 LDW completion SHALL set O_DestValue=I_MemRData, O_RegWrite=1, and update NZP from the load data.
REQ-019 STW completion SHALL set O_RegWrite=0 and leave NZP unchanged.
REQ-020 O_MemBusy SHALL be 1 in every WAIT cycle and during the acceptance-to-WAIT edge, i.e. combinationally high when FSM!=IDLE; writeback outputs SHALL show bubbles while busy.
REQ-021 A wait counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-022 When the wait counter reaches MEM_TIMEOUT without ack, the block SHALL drop O_MemReq, return to IDLE, retire the op with O_RegWrite=0, and set O_MemErr=1 until reset.
REQ-023 BRx SHALL be taken iff (n&N)|(z&Z)|(p&P), with the n/z/p bits taken from the opcode; JMP SHALL always be taken.
REQ-024 A taken branch SHALL pulse O_BranchTaken=1 for exactly one cycle with O_BranchPC=I_DestValue[PC_WIDTH-1:0]; branches SHALL not write registers.
REQ-025 JSR/JSRR SHALL be taken, set O_DestValue=I_ALUOut (link), set O_RegWrite=1 to I_DestRegIdx, and leave NZP unchanged.
REQ-026 I_LOCK falling mid-WAIT SHALL NOT abort the transaction; completion proceeds, and any new acceptance waits for IDLE.
REQ-027 Unknown opcodes SHALL retire as bubbles.

Reset
REQ-028 On I_RESET=1 at a negedge, the block SHALL force FSM=IDLE, wait counter=0, NZP=3'b010, and all outputs 0, including O_MemReq, O_MemErr, O_LOCK, O_RegWrite, and O_BranchTaken.
REQ-029 Reset mid-WAIT SHALL drop O_MemReq on that edge and discard the in-flight op; no writeback shall occur.
REQ-030 Reset SHALL take priority over ack, timeout, and acceptance in the same cycle.

Verification
REQ-031 ADDI with I_ALUOut=16'hFFFE -> next edge O_DestValue=16'hFFFE, O_RegWrite=1, NZP=100.
REQ-032 LDW with addr 16'h0040 and ack after 3 cycles returning 16'h1234 -> O_MemAddr held at 16'h0040 for 3 cycles, O_MemBusy high during the wait, O_DestValue=16'h1234, O_RegWrite=1.
REQ-033 STW with addr 16'h0010 and data 16'h00AB, with the ack never asserted and MEM_TIMEOUT=4 -> O_MemReq drops after 4 WAIT cycles, O_MemErr=1 persists until reset, O_RegWrite=0.
REQ-034 NZP=010 then BRZ with target 16'h0100 -> one-cycle O_BranchTaken=1 with O_BranchPC=0x0100; BRP under the same NZP -> O_BranchTaken=0.
REQ-035 I_RESET asserted during LD_WAIT with ack in the same cycle -> O_MemReq=0, no O_RegWrite, FSM IDLE, NZP=010.
REQ-036 I_DepStall=1 with ADD presented -> O_RegWrite=0 and O_DepStall=1 one edge later.
